// File: rtl/sc_io_pkg.sv
// Shared seven-segment glyphs and FSM state encoding for the hex display peripheral.
package sc_io_pkg;

    // Active-low segment order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

endpackage

// File: rtl/sc_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; codes above 9 show blank.
module sc_bcd_to_seg
    import sc_io_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // NOTE: assigning a default before the conditional keeps every path driven, so no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/sc_io_hex_display.sv
// out_port0 word -> decimal seven-segment digits via a serial double-dabble engine.
// Define SC_HEX_LEADING_ZERO_BLANK_EN to blank leading zero digits above hex[0].
module sc_io_hex_display
    import sc_io_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int IN_WIDTH = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value_in,
    output logic [6:0]  hex [DIGITS],
    output logic        busy,
    output logic        update
);

    localparam int              BCD_W     = 4 * DIGITS;
    localparam int              SR_W      = BCD_W + IN_WIDTH;
    localparam int              CNT_W     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [31:0]     OVF_LIMIT = 32'(10 ** DIGITS);

    state_t            state;
    logic              pending;
    logic              ovf;
    logic [31:0]       captured;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_next;
    logic [6:0]        seg  [DIGITS];
    logic [6:0]        disp [DIGITS];

    // One double-dabble step: correct nibbles >= 5, then shift the whole register left.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[IN_WIDTH + 4*d +: 4] >= 4'd5) begin
                sr_adj[IN_WIDTH + 4*d +: 4] = sr[IN_WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dec
        sc_bcd_to_seg u_dec (
            .bcd (sr[IN_WIDTH + 4*d +: 4]),
            .seg (seg[d])
        );
    end

`ifdef SC_HEX_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // Scan from the most significant digit; hex[0] always shows its glyph.
    always_comb begin
        disp      = '{default: SEG_BLANK};
        lead_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            lead_zero = lead_zero && (sr[IN_WIDTH + 4*d +: 4] == 4'd0);
            if (ovf) begin
                disp[d] = SEG_DASH;
            end else if (lead_zero && (d != 0)) begin
                disp[d] = SEG_BLANK;
            end else begin
                disp[d] = seg[d];
            end
        end
    end
`else
    always_comb begin
        disp = '{default: SEG_BLANK};
        for (int d = 0; d < DIGITS; d++) begin
            disp[d] = ovf ? SEG_DASH : seg[d];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= 1'b1;
            captured <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            sr       <= '0;
            busy     <= 1'b0;
            update   <= 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                hex[d] <= SEG_BLANK;
            end
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending || (value_in != captured)) begin
                        captured <= value_in;
                        ovf      <= (value_in >= OVF_LIMIT);
                        pending  <= 1'b0;
                        sr       <= {{BCD_W{1'b0}}, value_in[IN_WIDTH-1:0]};
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int d = 0; d < DIGITS; d++) begin
                        hex[d] <= disp[d];
                    end
                    update <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_io_hex_display.sv
// Scoreboard bench: the driver pushes the expected display and update cycle, the monitor pops on each update pulse.
module tb_sc_io_hex_display;

    localparam int DIGITS = 6;
    localparam int LAT    = 22;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [63:0] disp;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] value_in;
    logic [6:0]  hex [DIGITS];
    logic        busy;
    logic        update;

    exp_t        sb [$];
    int          cyc        = 0;
    int          checks     = 0;
    int          errors     = 0;
    int          upd_count  = 0;
    int          busy_run   = 0;
    int          apply_cyc  = 0;
    logic [31:0] last_v     = '0;

    sc_io_hex_display #(.DIGITS(DIGITS), .IN_WIDTH(20)) dut (
        .clock    (clock),
        .reset    (reset),
        .value_in (value_in),
        .hex      (hex),
        .busy     (busy),
        .update   (update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack_hex();
        logic [63:0] r = '0;
        for (int d = 0; d < DIGITS; d++) r[7*d +: 7] = hex[d];
        return r;
    endfunction

    // Reference: decimal digits by division, dashes when the value needs more than six digits.
    function automatic logic [63:0] expected_disp(input logic [31:0] v);
        logic [63:0] r = '0;
        logic [6:0]  g;
        int unsigned p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v >= 32'd1000000) begin
                g = G_DASH;
            end else begin
                g = GLYPH[(v / p) % 10];
`ifdef SC_HEX_LEADING_ZERO_BLANK_EN
                if (d > 0 && v < p) g = G_BLANK;
`endif
            end
            r[7*d +: 7] = g;
            p = p * 10;
        end
        return r;
    endfunction

    // Monitor: busy run length per conversion, and display/latency on every update pulse.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            check("busy_len", 64'(busy_run), 64'(20));
            busy_run = 0;
        end
        if (update) begin
            upd_count++;
            check("update_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("display", pack_hex(), e.disp);
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic apply(input logic [31:0] v);
        @(posedge clock);
        #1;
        value_in  = v;
        apply_cyc = cyc;
        if (v != last_v) sb.push_back('{expected_disp(v), cyc + LAT});
        last_v = v;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    logic [31:0] directed [8] = '{
        32'd123456, 32'd999999, 32'd1000000, 32'hFFFF_FFFF,
        32'd0, 32'd1, 32'd100000, 32'd999999
    };

    initial begin
        int n0;
        int r;
        logic [31:0] v;

        reset    = 1'b1;
        value_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_hex", pack_hex(), {22'd0, {DIGITS{G_BLANK}}});
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_update", 64'(update), 64'(0));

        // Pending flag forces a conversion of 0 with no input change.
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.push_back('{expected_disp(32'd0), cyc + LAT});
        drain();

        n0 = upd_count;
        repeat (40) @(posedge clock);
        check("no_reconvert", 64'(upd_count), 64'(n0));

        foreach (directed[i]) begin
            apply(directed[i]);
            drain();
        end

        // Change the input mid-conversion: 42 shows first, 77 follows a full latency later.
        apply(32'd42);
        repeat (6) @(posedge clock);
        #1;
        value_in = 32'd77;
        last_v   = 32'd77;
        sb.push_back('{expected_disp(32'd77), apply_cyc + 2*LAT});
        drain();

        // Abort a conversion with reset; the forced conversion then shows the held input.
        @(posedge clock);
        #1;
        value_in = 32'd555555;
        last_v   = 32'd555555;
        repeat (11) @(posedge clock);
        #1;
        check("busy_mid", 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_hex", pack_hex(), {22'd0, {DIGITS{G_BLANK}}});
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.push_back('{expected_disp(32'd555555), cyc + LAT});
        drain();

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      v = $urandom;
            else if (r == 1) v = last_v;
            else if (r < 4)  v = $urandom_range(0, 99);
            else             v = $urandom_range(0, 999999);
            apply(v);
            drain();
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (30) @(posedge clock);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
